// File: rtl/song_pkg.sv
// song_pkg: shared state encoding and event-word layout
// for the song sequencer and its helpers.
package song_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_LOAD,
      S_PLAY,
      S_PAUSED
   } state_t;

   localparam int NOTE_LSB = 0;
   localparam int NOTE_W   = 6;
   localparam int DUR_LSB  = 6;
   // gap and end flags sit directly above the duration field
   localparam int GAP_OFS  = 0;
   localparam int END_OFS  = 1;

   localparam logic [NOTE_W-1:0] REST_CODE = 6'd0;
   localparam logic [NOTE_W-1:0] NOTE_MAX  = 6'd36;

   function automatic logic gate_on(
      input logic sounding,
      input logic gap,
      input logic last
   );
      return sounding & ~(gap & last);
   endfunction

endpackage

// File: rtl/tempo_div.sv
// tempo_div: free-running tick divider; tick marks the
// cycle on which the counter wraps while running.
module tempo_div #(
   parameter int TICK_DIV = 6250000
)(
   input  logic clk50,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = run && (cnt == LAST);

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (run)
         cnt <= tick ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks an event memory and plays notes
// with tick-based durations, gaps, pause and looping.
module song_sequencer
   import song_pkg::*;
#(
   parameter int TICK_DIV = 6250000,
   parameter int ADDR_W   = 9,
   parameter int DUR_W    = 8
)(
   input  logic              clk50,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] loop_addr,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DUR_W+7:0]  rom_data,
   output logic [NOTE_W-1:0] note,
   output logic              gate,
   output logic              busy,
   output logic              done,
   output logic              tick
);

   localparam int GAP_B = DUR_LSB + DUR_W + GAP_OFS;
   localparam int END_B = DUR_LSB + DUR_W + END_OFS;

   state_t            state;
   logic [DUR_W-1:0]  remaining;
   logic [DUR_W-1:0]  rem_dec;
   logic [DUR_W-1:0]  ev_dur;
   logic [DUR_W-1:0]  ev_len;
   logic [NOTE_W-1:0] ev_code;
   logic              ev_gap;
   logic              ev_end;
   logic              ev_on;
   logic              sounding;
   logic              gap_r;
   logic              loaded;
   logic              run;
   logic              clear;
   logic              wrap;

   assign ev_code = rom_data[NOTE_LSB +: NOTE_W];
   assign ev_dur  = rom_data[DUR_LSB +: DUR_W];
   assign ev_gap  = rom_data[GAP_B];
   assign ev_end  = rom_data[END_B];
   assign ev_on   = (ev_code != REST_CODE);
   assign ev_len  = (ev_dur == '0) ? DUR_W'(1) : ev_dur;
   assign rem_dec = remaining - 1'b1;

   // PAUSED counts on its release edge so a pause costs exactly its length
   assign run   = (state == S_PLAY || state == S_PAUSED) && !pause;
   assign clear = stop || start || (state == S_LOAD);

   tempo_div #(
      .TICK_DIV (TICK_DIV)
   ) u_div (
      .clk50 (clk50),
      .reset (reset),
      .run   (run),
      .clear (clear),
      .tick  (wrap)
   );

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         rom_addr  <= '0;
         note      <= REST_CODE;
         gate      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tick      <= 1'b0;
         remaining <= '0;
         sounding  <= 1'b0;
         gap_r     <= 1'b0;
         loaded    <= 1'b0;
      end else begin
         done <= 1'b0;
         tick <= 1'b0;
         if (stop) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            note      <= REST_CODE;
            gate      <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
            loaded    <= 1'b0;
         end else if (start) begin
            state     <= S_FETCH;
            rom_addr  <= '0;
            note      <= REST_CODE;
            gate      <= 1'b0;
            busy      <= 1'b1;
            remaining <= '0;
            loaded    <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE:  state <= S_IDLE;
               S_FETCH: state <= S_WAIT;
               S_WAIT:  state <= S_LOAD;
               S_LOAD: begin
                  if (!ev_end) begin
                     note      <= ev_code;
                     remaining <= ev_len;
                     sounding  <= ev_on;
                     gap_r     <= ev_gap;
                     loaded    <= 1'b1;
                     state     <= pause ? S_PAUSED : S_PLAY;
                     gate      <= !pause &&
                        gate_on(ev_on, ev_gap, ev_len == DUR_W'(1));
                  end else if (loop_en && loaded) begin
                     rom_addr <= loop_addr;
                     loaded   <= 1'b0;
                     state    <= S_FETCH;
                  end else begin
                     note  <= REST_CODE;
                     gate  <= 1'b0;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
               S_PLAY, S_PAUSED: begin
                  if (pause) begin
                     gate  <= 1'b0;
                     state <= S_PAUSED;
                  end else begin
                     state <= S_PLAY;
                     gate  <= gate_on(sounding, gap_r,
                                      remaining == DUR_W'(1));
                     if (wrap) begin
                        tick      <= 1'b1;
                        remaining <= rem_dec;
                        if (rem_dec == '0) begin
                           rom_addr <= rom_addr + 1'b1;
                           state    <= S_FETCH;
                        end else begin
                           gate <= gate_on(sounding, gap_r,
                                           rem_dec == DUR_W'(1));
                        end
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
